// File: rtl/rr_arb_pkg.sv
// Shared constants for the 2:1 round-robin arbiter: source encoding and
// the reset value of the priority pointer.
package rr_arb_pkg;

  localparam logic SRC_A      = 1'b1;
  localparam logic SRC_B      = 1'b0;
  localparam logic PRIO_RESET = 1'b1;

endpackage

// File: rtl/rr_arb_2x1_mux.sv
// Single-bit 2:1 multiplexer; sel=1 picks a, sel=0 picks b.
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/rr_arb_2x1.sv
// Two-input round-robin arbiter with one registered output slot.
// Grants are combinational; prio and the output register share one clocked process.
module rr_arb_2x1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  logic             prio;
  logic             load;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = (prio == SRC_A);
      grant_b = (prio == SRC_B);
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // The slot can take a new word when empty or when it is drained this cycle.
  assign load    = !out_valid || out_ready;
  assign a_ready = !rst && load && grant_a;
  assign b_ready = !rst && load && grant_b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2x1 u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (grant_a),
      .y   (sel_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_B;
      prio      <= PRIO_RESET;
    end else if (load) begin
      if (grant_a || grant_b) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= grant_a ? SRC_A : SRC_B;
        prio      <= grant_a ? SRC_B : SRC_A;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_2x1.sv
// Bench for rr_arb_2x1: directed vector table, a sustained-throughput sequence,
// and randomized traffic against a transaction-level reference model.
module tb_rr_arb_2x1;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  int checks = 0;
  int errors = 0;

  rr_arb_2x1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each row is one cycle: inputs applied, then readies (this cycle) and the
  // output register (state from earlier edges) compared before the clock edge.
  typedef struct {
    logic             rst;
    logic             av;
    logic [WIDTH-1:0] ad;
    logic             bv;
    logic [WIDTH-1:0] bd;
    logic             ordy;
    logic             ear;
    logic             ebr;
    logic             eov;
    logic [WIDTH-1:0] edata;
    logic             esrc;
    logic             chk_ov;
    logic             chk_data;
  } vec_t;

  vec_t tbl[23];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: the word sitting in the output slot and which
  // channel wins the next tie.
  bit               m_full;
  logic [WIDTH-1:0] m_word;
  bit               m_from_a;
  bit               m_a_first;

  initial begin
    int               winner;
    bit               can_take;
    logic [WIDTH-1:0] prev_word;

    //          rst av ad     bv bd     or  ar br ov data   src cov cdat
    tbl[0]  = '{1, 1, 8'h11, 1, 8'h22, 1,  0, 0, 0, 8'h00, 0,  0,  0};
    tbl[1]  = '{1, 1, 8'h11, 1, 8'h22, 1,  0, 0, 0, 8'h00, 0,  1,  1};
    tbl[2]  = '{0, 1, 8'h11, 1, 8'h22, 1,  1, 0, 0, 8'h00, 0,  1,  0};
    tbl[3]  = '{0, 1, 8'h11, 1, 8'h22, 1,  0, 1, 1, 8'h11, 1,  1,  1};
    tbl[4]  = '{0, 1, 8'h11, 1, 8'h22, 1,  1, 0, 1, 8'h22, 0,  1,  1};
    tbl[5]  = '{0, 1, 8'h11, 1, 8'h22, 1,  0, 1, 1, 8'h11, 1,  1,  1};
    tbl[6]  = '{0, 0, 8'h00, 1, 8'h5A, 1,  0, 1, 1, 8'h22, 0,  1,  1};
    tbl[7]  = '{0, 0, 8'h00, 1, 8'h5A, 1,  0, 1, 1, 8'h5A, 0,  1,  1};
    tbl[8]  = '{0, 0, 8'h00, 1, 8'h5A, 1,  0, 1, 1, 8'h5A, 0,  1,  1};
    tbl[9]  = '{0, 1, 8'h33, 0, 8'h00, 1,  1, 0, 1, 8'h5A, 0,  1,  1};
    tbl[10] = '{0, 1, 8'h44, 1, 8'h55, 0,  0, 0, 1, 8'h33, 1,  1,  1};
    tbl[11] = '{0, 1, 8'h44, 1, 8'h55, 0,  0, 0, 1, 8'h33, 1,  1,  1};
    tbl[12] = '{0, 1, 8'h44, 1, 8'h55, 0,  0, 0, 1, 8'h33, 1,  1,  1};
    tbl[13] = '{0, 1, 8'h44, 1, 8'h55, 0,  0, 0, 1, 8'h33, 1,  1,  1};
    tbl[14] = '{0, 1, 8'h44, 1, 8'h55, 1,  0, 1, 1, 8'h33, 1,  1,  1};
    tbl[15] = '{0, 1, 8'h7E, 0, 8'h00, 1,  1, 0, 1, 8'h55, 0,  1,  1};
    tbl[16] = '{0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h7E, 1,  1,  1};
    tbl[17] = '{0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0,  1,  0};
    tbl[18] = '{0, 1, 8'h99, 1, 8'hAA, 0,  0, 1, 0, 8'h00, 0,  1,  0};
    tbl[19] = '{1, 1, 8'h99, 1, 8'hAA, 0,  0, 0, 1, 8'hAA, 0,  1,  1};
    tbl[20] = '{0, 1, 8'h99, 1, 8'hAA, 1,  1, 0, 0, 8'h00, 0,  1,  1};
    tbl[21] = '{0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 1, 8'h99, 1,  1,  1};
    tbl[22] = '{0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0,  1,  0};

    rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; out_ready = 1'b0;
    next_cycle();

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; a_valid = tbl[i].av; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_data = tbl[i].bd; out_ready = tbl[i].ordy;
      #2;
      check($sformatf("vec%0d a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
      check($sformatf("vec%0d b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
      if (tbl[i].chk_ov)
        check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      if (tbl[i].chk_data) begin
        check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].edata));
        check($sformatf("vec%0d out_src", i), 32'(out_src), 32'(tbl[i].esrc));
      end
      next_cycle();
    end

    // Sustained throughput: both channels always valid with fresh data, consumer
    // always ready -> one grant every cycle, each word visible the next cycle.
    rst = 1'b1; out_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    next_cycle();
    rst = 1'b0;
    prev_word = '0;
    for (int i = 0; i < 10; i++) begin
      a_data = WIDTH'($urandom);
      b_data = WIDTH'($urandom);
      #2;
      check($sformatf("thru%0d one_grant", i), 32'(a_ready + b_ready), 32'd1);
      check($sformatf("thru%0d a_turn", i), 32'(a_ready), 32'((i % 2) == 0));
      if (i > 0) begin
        check($sformatf("thru%0d out_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("thru%0d out_data", i), 32'(out_data), 32'(prev_word));
      end
      prev_word = a_ready ? a_data : b_data;
      next_cycle();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst       = (i == 0) || ($urandom_range(0, 39) == 0);
      a_valid   = $urandom_range(0, 1) == 1;
      b_valid   = $urandom_range(0, 1) == 1;
      a_data    = WIDTH'($urandom);
      b_data    = WIDTH'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #2;
      can_take = !m_full || out_ready;
      if (a_valid && b_valid) winner = m_a_first ? 1 : 2;
      else if (a_valid)       winner = 1;
      else if (b_valid)       winner = 2;
      else                    winner = 0;

      check($sformatf("rnd%0d a_ready", i), 32'(a_ready), 32'(!rst && can_take && winner == 1));
      check($sformatf("rnd%0d b_ready", i), 32'(b_ready), 32'(!rst && can_take && winner == 2));
      if (i > 0) begin
        check($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(m_full));
        if (m_full) begin
          check($sformatf("rnd%0d out_data", i), 32'(out_data), 32'(m_word));
          check($sformatf("rnd%0d out_src", i), 32'(out_src), 32'(m_from_a));
        end
      end
      next_cycle();

      if (rst) begin
        m_full    = 0;
        m_word    = '0;
        m_from_a  = 0;
        m_a_first = 1;
      end else if (can_take) begin
        if (winner != 0) begin
          m_full    = 1;
          m_word    = (winner == 1) ? a_data : b_data;
          m_from_a  = (winner == 1);
          m_a_first = (winner == 2);
        end else begin
          m_full = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
